multiport_main_memory: RTL and testbench

- Word-addressed main memory shared by several requesters through a message/address/data protocol.
- Port 0 serves the core's cache interface; port 1 serves the secure line-crossbar (encrypted/plain image, words 0-4095 encrypted, 4096-8191 plaintext).
- Built on a single-ported BRAM with a round-robin arbiter. At most one request is serviced per cycle, with a fixed one-cycle registered response.

---
 rtl/mem_msg_pkg.sv | 17 +
 rtl/bram_sp.sv | 27 ++
 rtl/multiport_main_memory.sv | 130 +++++++++++++
 tb/tb_multiport_main_memory.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/mem_msg_pkg.sv
// Message codes shared by the main memory and its requesters.
package mem_msg_pkg;

  localparam int MSG_W = 3;

  // Request codes driven by requesters
  localparam logic [MSG_W-1:0] NO_REQ = 3'd0;
  localparam logic [MSG_W-1:0] WB_REQ = 3'd1;
  localparam logic [MSG_W-1:0] R_REQ  = 3'd2;
  localparam logic [MSG_W-1:0] FLUSH  = 3'd3;

  // Response codes returned by the memory
  localparam logic [MSG_W-1:0] MEM_NO_MSG = 3'd0;
  localparam logic [MSG_W-1:0] MEM_READY  = 3'd1;
  localparam logic [MSG_W-1:0] MEM_SENT   = 3'd2;

endpackage

// File: rtl/bram_sp.sv
// Single-ported block RAM with synchronous write and synchronous read.
module bram_sp #(
   parameter int    DATA_WIDTH = 32,
   parameter int    INDEX_BITS = 13,
   parameter string INIT_FILE  = ""
) (
   input  logic                  clock,
   input  logic                  i_we,
   input  logic                  i_re,
   input  logic [INDEX_BITS-1:0] i_index,
   input  logic [DATA_WIDTH-1:0] i_wdata,
   output logic [DATA_WIDTH-1:0] o_rdata
);

   logic [DATA_WIDTH-1:0] mem [0:2**INDEX_BITS-1];
   logic [DATA_WIDTH-1:0] r_rdata;

   // One access per cycle: either store a word or capture a read word.
   // Contents are never touched by reset.
   always_ff @(posedge clock) begin
      if (i_we) mem[i_index] <= i_wdata;
      if (i_re) r_rdata <= mem[i_index];
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/multiport_main_memory.sv
// Multi-requester main memory: round-robin arbitration onto one BRAM port
// with a one-cycle registered response to the granted requester.
module multiport_main_memory
  import mem_msg_pkg::*;
#(
  parameter int    DATA_WIDTH    = 32,
  parameter int    ADDRESS_WIDTH = 13,
  parameter int    MSG_BITS      = 3,
  parameter int    INDEX_BITS    = 13,
  parameter int    NUM_PORTS     = 2,
  parameter string INIT_FILE     = ""
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic [NUM_PORTS*MSG_BITS-1:0]      msg_in,
  input  logic [NUM_PORTS*ADDRESS_WIDTH-1:0] address,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]    data_in,
  output logic [NUM_PORTS*MSG_BITS-1:0]      msg_out,
  output logic [NUM_PORTS*ADDRESS_WIDTH-1:0] address_out,
  output logic [NUM_PORTS*DATA_WIDTH-1:0]    data_out
);

  localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [PTR_W-1:0]         r_ptr;
  logic [NUM_PORTS-1:0]     r_pending;
  logic                     r_respRead;
  logic [ADDRESS_WIDTH-1:0] r_respAddr;
  logic [DATA_WIDTH-1:0]    r_respWData;

  logic [NUM_PORTS-1:0]     w_eligible;
  logic                     w_grantValid;
  logic [PTR_W-1:0]         w_grant;
  logic [MSG_BITS-1:0]      w_grantMsg;
  logic [ADDRESS_WIDTH-1:0] w_grantAddr;
  logic [DATA_WIDTH-1:0]    w_grantData;
  logic                     w_grantWrite;
  logic                     w_grantRead;
  logic [DATA_WIDTH-1:0]    w_rdata;
  logic [PTR_W-1:0]         w_nextPtr;

  // A port competes only with a real request and while it is not already
  // looking at a response, so a held request is never served twice.
  always_comb begin
    logic [MSG_BITS-1:0] m;
    m          = '0;
    w_eligible = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      m = msg_in[p*MSG_BITS +: MSG_BITS];
      w_eligible[p] = ((m == MSG_BITS'(WB_REQ)) || (m == MSG_BITS'(FLUSH)) ||
                       (m == MSG_BITS'(R_REQ))) && !r_pending[p];
    end
  end

  // Round-robin search starting at the current priority pointer.
  always_comb begin
    int idx;
    idx          = 0;
    w_grantValid = 1'b0;
    w_grant      = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      idx = (int'(r_ptr) + k) % NUM_PORTS;
      if (!w_grantValid && w_eligible[idx]) begin
        w_grantValid = 1'b1;
        w_grant      = PTR_W'(idx);
      end
    end
  end

  // Route the granted port's request onto the shared BRAM port.
  always_comb begin
    w_grantMsg   = msg_in[int'(w_grant)*MSG_BITS +: MSG_BITS];
    w_grantAddr  = address[int'(w_grant)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
    w_grantData  = data_in[int'(w_grant)*DATA_WIDTH +: DATA_WIDTH];
    w_grantWrite = w_grantValid && ((w_grantMsg == MSG_BITS'(WB_REQ)) ||
                                    (w_grantMsg == MSG_BITS'(FLUSH)));
    w_grantRead  = w_grantValid && (w_grantMsg == MSG_BITS'(R_REQ));
    w_nextPtr    = (w_grant == PTR_W'(NUM_PORTS - 1)) ? '0 : w_grant + PTR_W'(1);
  end

  // A request seen together with reset is dropped: no store, no read.
  bram_sp #(
    .DATA_WIDTH(DATA_WIDTH),
    .INDEX_BITS(INDEX_BITS),
    .INIT_FILE (INIT_FILE)
  ) BRAM (
    .clock  (clock),
    .i_we   (w_grantWrite && !reset),
    .i_re   (w_grantRead && !reset),
    .i_index(w_grantAddr[INDEX_BITS-1:0]),
    .i_wdata(w_grantData),
    .o_rdata(w_rdata)
  );

  // Register the grant so the response is visible for exactly one cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_ptr       <= '0;
      r_pending   <= '0;
      r_respRead  <= 1'b0;
      r_respAddr  <= '0;
      r_respWData <= '0;
    end else begin
      r_pending <= '0;
      if (w_grantValid) begin
        r_pending[w_grant] <= 1'b1;
        r_ptr              <= w_nextPtr;
        r_respRead         <= w_grantRead;
        r_respAddr         <= w_grantAddr;
        r_respWData        <= w_grantData;
      end
    end
  end

  // Only the port owning the current response sees non-zero outputs.
  always_comb begin
    msg_out     = '0;
    address_out = '0;
    data_out    = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (r_pending[p]) begin
        msg_out[p*MSG_BITS +: MSG_BITS] =
          r_respRead ? MSG_BITS'(MEM_SENT) : MSG_BITS'(MEM_READY);
        address_out[p*ADDRESS_WIDTH +: ADDRESS_WIDTH] = r_respAddr;
        data_out[p*DATA_WIDTH +: DATA_WIDTH] = r_respRead ? w_rdata : r_respWData;
      end
    end
  end

endmodule

// File: tb/tb_multiport_main_memory.sv
// Directed bench for the two-port main memory.
module tb_multiport_main_memory;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  m0 = '0, m1 = '0;
  logic [12:0] a0 = '0, a1 = '0;
  logic [31:0] d0 = '0, d1 = '0;

  logic [5:0]  msg_in;
  logic [25:0] address;
  logic [63:0] data_in;
  logic [5:0]  msg_out;
  logic [25:0] address_out;
  logic [63:0] data_out;

  int vectors = 0;
  int miscompares = 0;

  assign msg_in  = {m1, m0};
  assign address = {a1, a0};
  assign data_in = {d1, d0};

  multiport_main_memory DUT (
    .clock      (clock),
    .reset      (reset),
    .msg_in     (msg_in),
    .address    (address),
    .data_in    (data_in),
    .msg_out    (msg_out),
    .address_out(address_out),
    .data_out   (data_out)
  );

  always #5 clock = ~clock;

  // Advance one rising edge and settle before sampling or driving.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic [2:0] nm0, input logic [12:0] na0, input logic [31:0] nd0,
                               input logic [2:0] nm1, input logic [12:0] na1, input logic [31:0] nd1);
    m0 = nm0; a0 = na0; d0 = nd0;
    m1 = nm1; a1 = na1; d1 = nd1;
  endtask

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag,
                             input logic [2:0] em0, input logic [12:0] ea0, input logic [31:0] ed0,
                             input logic [2:0] em1, input logic [12:0] ea1, input logic [31:0] ed1);
    checkVal({tag, ".msg0"},  {29'd0, msg_out[2:0]},      {29'd0, em0});
    checkVal({tag, ".addr0"}, {19'd0, address_out[12:0]}, {19'd0, ea0});
    checkVal({tag, ".data0"}, data_out[31:0],             ed0);
    checkVal({tag, ".msg1"},  {29'd0, msg_out[5:3]},      {29'd0, em1});
    checkVal({tag, ".addr1"}, {19'd0, address_out[25:13]},{19'd0, ea1});
    checkVal({tag, ".data1"}, data_out[63:32],            ed1);
  endtask

  initial begin
    logic [31:0] wrapAddr;
    DUT.BRAM.mem[0]    = 32'hCAFEF00D;
    DUT.BRAM.mem[1]    = 32'h00001111;
    DUT.BRAM.mem[3]    = 32'hA5A5A5A5;
    DUT.BRAM.mem[5]    = 32'hDEADBEEF;
    DUT.BRAM.mem[10]   = 32'h00000011;
    DUT.BRAM.mem[4097] = 32'h00002222;

    // Reset held two cycles, then idle
    applyStimulus(3'd0, 13'd0, 32'd0, 3'd0, 13'd0, 32'd0);
    tick(); checkOutput("reset1", 0, 0, 0, 0, 0, 0);
    tick(); checkOutput("reset2", 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    tick(); checkOutput("idle", 0, 0, 0, 0, 0, 0);

    // Single read on port 0
    applyStimulus(3'd2, 13'd5, 32'd0, 3'd0, 13'd0, 32'd0);
    tick(); checkOutput("rd0", 3'd2, 13'd5, 32'hDEADBEEF, 0, 0, 0);
    applyStimulus(3'd0, 13'd0, 32'd0, 3'd0, 13'd0, 32'd0);
    tick(); checkOutput("rd0.after", 0, 0, 0, 0, 0, 0);

    // Write then read on port 1
    applyStimulus(3'd0, 13'd0, 32'd0, 3'd1, 13'd4100, 32'h12345678);
    tick(); checkOutput("wr1", 0, 0, 0, 3'd1, 13'd4100, 32'h12345678);
    applyStimulus(3'd0, 13'd0, 32'd0, 3'd0, 13'd0, 32'd0);
    tick(); checkOutput("wr1.after", 0, 0, 0, 0, 0, 0);
    applyStimulus(3'd0, 13'd0, 32'd0, 3'd2, 13'd4100, 32'd0);
    tick(); checkOutput("rd1", 0, 0, 0, 3'd2, 13'd4100, 32'h12345678);
    applyStimulus(3'd0, 13'd0, 32'd0, 3'd0, 13'd0, 32'd0);
    tick();

    // FLUSH behaves as a write
    applyStimulus(3'd3, 13'd20, 32'h0BADF00D, 3'd0, 13'd0, 32'd0);
    tick(); checkOutput("flush0", 3'd1, 13'd20, 32'h0BADF00D, 0, 0, 0);
    applyStimulus(3'd2, 13'd20, 32'd0, 3'd0, 13'd0, 32'd0);
    tick(); checkOutput("flush0.hold", 0, 0, 0, 0, 0, 0);
    tick(); checkOutput("flush0.rd", 3'd2, 13'd20, 32'h0BADF00D, 0, 0, 0);
    applyStimulus(3'd0, 13'd0, 32'd0, 3'd0, 13'd0, 32'd0);
    tick();

    // Simultaneous reads right after reset: port 0 first, then port 1
    reset = 1'b1;
    tick();
    reset = 1'b0;
    applyStimulus(3'd2, 13'd1, 32'd0, 3'd2, 13'd4097, 32'd0);
    tick(); checkOutput("both.first", 3'd2, 13'd1, 32'h00001111, 0, 0, 0);
    tick(); checkOutput("both.second", 0, 0, 0, 3'd2, 13'd4097, 32'h00002222);
    applyStimulus(3'd0, 13'd0, 32'd0, 3'd0, 13'd0, 32'd0);
    tick(); checkOutput("both.after", 0, 0, 0, 0, 0, 0);

    // Codes 4-7 are ignored
    applyStimulus(3'd6, 13'd5, 32'd0, 3'd4, 13'd5, 32'd0);
    tick(); checkOutput("badcode", 0, 0, 0, 0, 0, 0);

    // Address wrap: 8195 truncated to 13 bits is index 3
    wrapAddr = 32'd8195;
    applyStimulus(3'd2, wrapAddr[12:0], 32'd0, 3'd0, 13'd0, 32'd0);
    tick(); checkOutput("wrap", 3'd2, 13'd3, 32'hA5A5A5A5, 0, 0, 0);
    applyStimulus(3'd0, 13'd0, 32'd0, 3'd0, 13'd0, 32'd0);
    tick();

    // Reset in the grant cycle of a write discards it
    applyStimulus(3'd1, 13'd10, 32'h00000077, 3'd0, 13'd0, 32'd0);
    reset = 1'b1;
    tick(); checkOutput("rstwr", 0, 0, 0, 0, 0, 0);
    checkVal("rstwr.mem10", DUT.BRAM.mem[10], 32'h00000011);
    applyStimulus(3'd0, 13'd0, 32'd0, 3'd0, 13'd0, 32'd0);
    reset = 1'b0;
    tick(); checkOutput("rstwr.after", 0, 0, 0, 0, 0, 0);
    checkVal("rst.mem0", DUT.BRAM.mem[0], 32'hCAFEF00D);

    // Read both survivors back through the ports
    applyStimulus(3'd2, 13'd10, 32'd0, 3'd2, 13'd0, 32'd0);
    tick(); checkOutput("post.rd0", 3'd2, 13'd10, 32'h00000011, 0, 0, 0);
    tick(); checkOutput("post.rd1", 0, 0, 0, 3'd2, 13'd0, 32'hCAFEF00D);
    applyStimulus(3'd0, 13'd0, 32'd0, 3'd0, 13'd0, 32'd0);
    tick(); checkOutput("end.idle", 0, 0, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
